filter_gmii_mc_cpu_regs: RTL
============================

Name: filter_gmii_mc_cpu_regs

Overview:
Multi-channel AXI4-Lite register block for the GMII filter datapath, generalising the single-channel filter register set to NUM_CHANNELS ports. It provides global ID/VERSION/capability words, per-channel control and min-interframe-gap registers, and per-channel saturating clear-on-read packet and drop counters. Unmapped or illegal accesses return SLVERR. It sits between the AXI-Lite interconnect and NUM_CHANNELS filter_gmii instances.

Parameters:
C_BASE_ADDRESS, 32'h00000000, block base address; must be 4 KiB aligned, decoded as offset = ADDR ^ C_BASE_ADDRESS.
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 32, AXI address width.
NUM_CHANNELS, 4, channel count, 1..16.
IFG_WIDTH, 16, width of each min-interframe-gap field, max 32.
IFG_DEFAULT, 12, reset value of every MIN_IFG register.

Ports:
clk  in  1  single clock for all logic, including AXI.
reset  in  1  synchronous, active-high reset.
id_reg  in  32  value returned for ID.
version_reg  in  32  value returned for VERSION.
pkt_event  in  NUM_CHANNELS  one-cycle pulse per forwarded packet, one bit per channel.
drop_event  in  NUM_CHANNELS  one-cycle pulse per dropped packet, one bit per channel.
chan_enable  out  NUM_CHANNELS  CTRL[0] of each channel.
min_ifg_flat  out  NUM_CHANNELS*IFG_WIDTH  channel c occupies bits [c*IFG_WIDTH +: IFG_WIDTH].
S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite slave ports at the parameter widths.

Behaviour:
- Reset is on the clk edge while reset=1:
  - AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; RDATA = 0; BRESP, RRESP = 0.
  - chan_enable = 0; every MIN_IFG = IFG_DEFAULT; all counters = 0.
  - An in-flight transaction is abandoned; no partial write commits.
- Address map (offset bits [1:0] ignored):
  - 0x000 ID (RO); 0x004 VERSION (RO); 0x008 CAPS (RO) = {16'(IFG_WIDTH), 16'(NUM_CHANNELS)}.
  - Channel c at 0x100 + 0x10*c:
    - +0x0 CTRL: RW, bit0 = enable, other bits read 0.
    - +0x4 MIN_IFG: RW, upper bits read 0.
    - +0x8 PKT_CNT: RO, clear-on-read.
    - +0xC DROP_CNT: RO, clear-on-read.
  - Channels c >= NUM_CHANNELS are unmapped.
- Write channel:
  - AW and W are accepted independently.
  - AWREADY=1 while no address is held and BVALID=0; WREADY=1 while no data is held and BVALID=0.
  - Once both are held, the write commits on the next edge, BVALID rises on that same edge, and both holding slots clear.
  - WSTRB byte lanes apply to RW registers.
  - A write to an RO or unmapped address: no state change, BRESP=2'b10; otherwise BRESP=2'b00.
  - BVALID holds until BREADY. The next AW/W may be accepted on the cycle after the BVALID&BREADY handshake.
- Read channel:
  - ARREADY=1 while RVALID=0 and no read is pending.
  - Read latency is 1 cycle: on the edge after AR acceptance, RVALID=1 and RDATA/RRESP are registered from the address.
  - Unmapped address: RDATA=32'hDEADBEEF, RRESP=2'b10.
  - RDATA stays stable until the RVALID&RREADY handshake.
- Counters:
  - 32 bits, +1 per event pulse, saturating at 32'hFFFFFFFF (no wrap).
  - Clear-on-read happens on the same edge RDATA captures the value.
  - If an event coincides with that clear, the counter becomes 1; the returned value excludes that event.
  - Counters count regardless of chan_enable.
- Simultaneous read and write: independent. Any read of a register sees the value from before the edge on which a write to it commits.

Test Plan:
- Reset, then read 0x000, 0x004, 0x008 with id_reg=32'hCAFE0001, NUM_CHANNELS=4, IFG_WIDTH=16 -> RDATA 32'hCAFE0001, version_reg, 32'h00100004; RRESP 0; RVALID exactly 1 cycle after AR handshake.
- Write 32'h0000_0020 to 0x114 with WSTRB=4'b0001, W issued 3 cycles before AW -> min_ifg_flat[31:16]=16'h0020, BRESP 0; then WSTRB=4'b0010 with data 32'h0000_0100 -> reads back 32'h0000_0120.
- 5 pkt_event pulses on channel 2, read 0x128 -> 5; re-read -> 0; a pulse on the clearing-read edge -> read returns the old value, the following read returns 1.
- Preload channel 0 DROP_CNT to 32'hFFFFFFFE via events, then 3 drop_event pulses -> reads 32'hFFFFFFFF (saturated, no wrap).
- Read 0x140 (channel 4 with NUM_CHANNELS=4) and 0x020 -> 32'hDEADBEEF with RRESP 2'b10; write 0x108 -> BRESP 2'b10 and counter unchanged.
- Assert reset while BVALID=1 and BREADY=0 -> BVALID=0 the next cycle, CTRL=0, min_ifg_flat all 16'd12.

Source files
------------

// File: rtl/filter_gmii_mc_cpu_regs.sv
// AXI4-Lite register block for NUM_CHANNELS GMII filter ports: global ID/VERSION/CAPS,
// per-channel CTRL/MIN_IFG and saturating clear-on-read packet/drop counters.
module filter_gmii_mc_cpu_regs #(
  parameter logic [31:0] C_BASE_ADDRESS     = 32'h0000_0000,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
  parameter int unsigned NUM_CHANNELS       = 4,
  parameter int unsigned IFG_WIDTH          = 16,
  parameter int unsigned IFG_DEFAULT        = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [31:0]                       id_reg,
  input  logic [31:0]                       version_reg,
  input  logic [NUM_CHANNELS-1:0]           pkt_event,
  input  logic [NUM_CHANNELS-1:0]           drop_event,
  output logic [NUM_CHANNELS-1:0]           chan_enable,
  output logic [NUM_CHANNELS*IFG_WIDTH-1:0] min_ifg_flat,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);

  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] CAPS_VALUE = {16'(IFG_WIDTH), 16'(NUM_CHANNELS)};

  logic                 awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic                 bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]           bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]        rdata_q, rdata_d, wdata_q, wdata_d;
  logic [SW-1:0]        wstrb_q, wstrb_d;
  logic                 aw_held_q, aw_held_d, w_held_q, w_held_d, ar_pend_q, ar_pend_d;
  logic [AW-1:0]        awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [NUM_CHANNELS-1:0]                en_q, en_d;
  logic [NUM_CHANNELS-1:0][IFG_WIDTH-1:0] ifg_q, ifg_d;
  logic [NUM_CHANNELS-1:0][31:0]          pkt_q, pkt_d, drop_q, drop_d;

  logic [NUM_CHANNELS-1:0] pkt_clr, drop_clr;
  logic [AW-1:0]           rd_w, wr_w;
  logic [31:0]             rd_data;
  logic [1:0]              rd_resp;
  logic                    wr_ok;

  // Word index of an address relative to the block base; byte-offset bits drop out here.
  function automatic logic [AW-1:0] word_of(input logic [AW-1:0] addr);
    return (addr ^ AW'(C_BASE_ADDRESS)) >> 2;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] data,
                                              input logic [SW-1:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < int'(SW); b++) begin
      if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
    end
    return r;
  endfunction

  always_comb begin
    awready_d = awready_q;
    wready_d  = wready_q;
    arready_d = arready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ar_pend_d = ar_pend_q;
    araddr_d  = araddr_q;
    en_d      = en_q;
    ifg_d     = ifg_q;
    pkt_d     = pkt_q;
    drop_d    = drop_q;
    pkt_clr   = '0;
    drop_clr  = '0;
    rd_data   = 32'hDEAD_BEEF;
    rd_resp   = RESP_SLVERR;
    wr_ok     = 1'b0;
    rd_w      = word_of(araddr_q);
    wr_w      = word_of(awaddr_q);

    // Write address/data capture, commit once both are held
    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (awready_q && S_AXI_AWVALID) begin
      aw_held_d = 1'b1;
      awaddr_d  = S_AXI_AWADDR;
    end
    if (wready_q && S_AXI_WVALID) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if ((wr_w >> 6) == AW'(1)) begin
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
          if (wr_w[5:2] == 4'(c)) begin
            if (wr_w[1:0] == 2'd0) begin
              wr_ok = 1'b1;
              if (wstrb_q[0]) en_d[c] = wdata_q[0];
            end else if (wr_w[1:0] == 2'd1) begin
              wr_ok    = 1'b1;
              ifg_d[c] = IFG_WIDTH'(merge_bytes(32'(ifg_q[c]), wdata_q, wstrb_q));
            end
          end
        end
      end
      bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
    end

    // Read: address latched on acceptance, data registered one edge later
    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (arready_q && S_AXI_ARVALID) begin
      ar_pend_d = 1'b1;
      araddr_d  = S_AXI_ARADDR;
    end
    if (ar_pend_q) begin
      if ((rd_w >> 6) == AW'(0) && rd_w[5:2] == 4'd0) begin
        rd_resp = RESP_OKAY;
        case (rd_w[1:0])
          2'd0:    rd_data = id_reg;
          2'd1:    rd_data = version_reg;
          2'd2:    rd_data = CAPS_VALUE;
          default: begin
            rd_data = 32'hDEAD_BEEF;
            rd_resp = RESP_SLVERR;
          end
        endcase
      end else if ((rd_w >> 6) == AW'(1)) begin
        for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
          if (rd_w[5:2] == 4'(c)) begin
            rd_resp = RESP_OKAY;
            case (rd_w[1:0])
              2'd0:    rd_data = 32'(en_q[c]);
              2'd1:    rd_data = 32'(ifg_q[c]);
              2'd2: begin
                rd_data    = pkt_q[c];
                pkt_clr[c] = 1'b1;
              end
              default: begin
                rd_data     = drop_q[c];
                drop_clr[c] = 1'b1;
              end
            endcase
          end
        end
      end
      ar_pend_d = 1'b0;
      rvalid_d  = 1'b1;
      rdata_d   = DW'(rd_data);
      rresp_d   = rd_resp;
    end

    // Saturating counters; an event on the clearing edge survives as a count of one
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      if (pkt_clr[c])                               pkt_d[c] = 32'(pkt_event[c]);
      else if (pkt_event[c] && pkt_q[c] != '1)      pkt_d[c] = pkt_q[c] + 32'd1;
      if (drop_clr[c])                              drop_d[c] = 32'(drop_event[c]);
      else if (drop_event[c] && drop_q[c] != '1)    drop_d[c] = drop_q[c] + 32'd1;
    end

    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d && !ar_pend_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      aw_held_q <= 1'b0;
      awaddr_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ar_pend_q <= 1'b0;
      araddr_q  <= '0;
      en_q      <= '0;
      ifg_q     <= {NUM_CHANNELS{IFG_WIDTH'(IFG_DEFAULT)}};
      pkt_q     <= '0;
      drop_q    <= '0;
    end else begin
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      aw_held_q <= aw_held_d;
      awaddr_q  <= awaddr_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      ar_pend_q <= ar_pend_d;
      araddr_q  <= araddr_d;
      en_q      <= en_d;
      ifg_q     <= ifg_d;
      pkt_q     <= pkt_d;
      drop_q    <= drop_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign chan_enable   = en_q;
  assign min_ifg_flat  = ifg_q;

endmodule
